// File: rtl/wb_dest_pipe_sel.sv
// Write-back destination selector: picks one of N_SRC candidate register
// addresses, carries it through a DEPTH-stage valid-tagged pipeline with
// stall/flush, and flags read-after-write hazards against in-flight entries.
module wb_dest_pipe_sel #(
  parameter int ADDR_W      = 5,
  parameter int N_SRC       = 5,
  parameter int SEL_W       = 3,
  parameter int DEPTH       = 2,
  parameter int SUPPRESS_R0 = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_SRC*ADDR_W-1:0]   src_addr,
  input  logic [SEL_W-1:0]          sel,
  input  logic                      sel_valid,
  input  logic                      stall,
  input  logic                      flush,
  input  logic [ADDR_W-1:0]         rd_addr_a,
  input  logic [ADDR_W-1:0]         rd_addr_b,
  output logic [ADDR_W-1:0]         wb_addr,
  output logic                      wb_valid,
  output logic                      hazard_a,
  output logic                      hazard_b,
  output logic [2:0]                inflight,
  output logic                      sel_err
);

  localparam logic [SEL_W:0] NSRC_L = (SEL_W+1)'(N_SRC);

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [DEPTH-1:0]             vld_q, vld_d;
  logic                         sel_err_q, sel_err_d;
  logic [ADDR_W-1:0]            sel_addr;
  logic                         sel_bad;
  logic                         cap_vld;

  // Source mux; out-of-range selects fall back to the last source
  always_comb begin
    sel_addr = src_addr[(N_SRC-1)*ADDR_W +: ADDR_W];
    for (int i = 0; i < N_SRC; i++)
      if (sel == SEL_W'(i)) sel_addr = src_addr[i*ADDR_W +: ADDR_W];
  end

  assign sel_bad = ({1'b0, sel} >= NSRC_L);
  // Writes to r0 are architecturally dead, so they never become valid
  assign cap_vld = sel_valid && !((SUPPRESS_R0 != 0) && (sel_addr == '0));

  // Next-state: flush beats stall beats normal shift
  always_comb begin
    addr_d    = addr_q;
    vld_d     = vld_q;
    sel_err_d = sel_err_q;
    if (flush) begin
      vld_d = '0;
    end else if (!stall) begin
      addr_d[0] = sel_addr;
      vld_d[0]  = cap_vld;
      for (int k = 1; k < DEPTH; k++) begin
        addr_d[k] = addr_q[k-1];
        vld_d[k]  = vld_q[k-1];
      end
      if (sel_valid && sel_bad) sel_err_d = 1'b1;
    end
  end

  // Pipeline registers and sticky select-error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      vld_q     <= '0;
      sel_err_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      vld_q     <= vld_d;
      sel_err_q <= sel_err_d;
    end
  end

  // Hazard match and occupancy count, from registered state only
  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    inflight = 3'd0;
    for (int k = 0; k < DEPTH; k++) begin
      inflight = inflight + 3'(vld_q[k]);
      if (vld_q[k] && (rd_addr_a != '0) && (addr_q[k] == rd_addr_a)) hazard_a = 1'b1;
      if (vld_q[k] && (rd_addr_b != '0) && (addr_q[k] == rd_addr_b)) hazard_b = 1'b1;
    end
  end

  assign wb_addr  = addr_q[DEPTH-1];
  assign wb_valid = vld_q[DEPTH-1];
  assign sel_err  = sel_err_q;

endmodule

// File: tb/tb_wb_dest_pipe_sel.sv
// Directed bench for wb_dest_pipe_sel: default build (DEPTH=2, N_SRC=5)
// plus DEPTH=1 and DEPTH=4 builds with eight sources.
module tb_wb_dest_pipe_sel;

  logic        clk = 1'b0;
  logic        reset;
  logic [24:0] src5;
  logic [39:0] src8;
  logic [2:0]  sel;
  logic        sel_valid, stall, flush;
  logic [4:0]  rd_addr_a, rd_addr_b;

  logic [4:0] wb_addr0, wb_addr1, wb_addr4;
  logic       wb_valid0, wb_valid1, wb_valid4;
  logic       haz_a0, haz_b0, haz_a1, haz_b1, haz_a4, haz_b4;
  logic [2:0] infl0, infl1, infl4;
  logic       serr0, serr1, serr4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_dest_pipe_sel u0 (
    .clk(clk), .reset(reset), .src_addr(src5), .sel(sel), .sel_valid(sel_valid),
    .stall(stall), .flush(flush), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .wb_addr(wb_addr0), .wb_valid(wb_valid0), .hazard_a(haz_a0), .hazard_b(haz_b0),
    .inflight(infl0), .sel_err(serr0));

  wb_dest_pipe_sel #(.N_SRC(8), .DEPTH(1)) u1 (
    .clk(clk), .reset(reset), .src_addr(src8), .sel(sel), .sel_valid(sel_valid),
    .stall(stall), .flush(flush), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .wb_addr(wb_addr1), .wb_valid(wb_valid1), .hazard_a(haz_a1), .hazard_b(haz_b1),
    .inflight(infl1), .sel_err(serr1));

  wb_dest_pipe_sel #(.N_SRC(8), .DEPTH(4)) u4 (
    .clk(clk), .reset(reset), .src_addr(src8), .sel(sel), .sel_valid(sel_valid),
    .stall(stall), .flush(flush), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .wb_addr(wb_addr4), .wb_valid(wb_valid4), .hazard_a(haz_a4), .hazard_b(haz_b4),
    .inflight(infl4), .sel_err(serr4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; sel = 3'd0; sel_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    src5 = {5'd31, 5'd29, 5'd8, 5'd5, 5'd3};
    src8 = {5'd17, 5'd16, 5'd15, 5'd14, 5'd13, 5'd12, 5'd11, 5'd10};
    tick(); tick();
    reset = 1'b0;

    // Reset mid-operation discards an in-flight entry immediately
    sel = 3'd2; sel_valid = 1'b1; rd_addr_a = 5'd8;
    tick();
    chk("pre_rst_infl", infl0, 1);
    chk("pre_rst_haz", haz_a0, 1);
    #3 reset = 1'b1;
    #1;
    chk("rst_infl", infl0, 0);
    chk("rst_haz", haz_a0, 0);
    chk("rst_wbv", wb_valid0, 0);
    chk("rst_wba", wb_addr0, 0);
    chk("rst_serr", serr0, 0);
    #1 reset = 1'b0; sel_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_infl", infl0, 0);
    end
    chk("idle_wbv", wb_valid0, 0);

    // Basic path: sel=2 -> address 8 appears at write-back two cycles later
    sel = 3'd2; sel_valid = 1'b1;
    tick();
    chk("bas_c1_wbv", wb_valid0, 0);
    chk("bas_c1_haz", haz_a0, 1);
    chk("bas_c1_infl", infl0, 1);
    sel_valid = 1'b0;
    tick();
    chk("bas_c2_wbv", wb_valid0, 1);
    chk("bas_c2_wba", wb_addr0, 8);
    chk("bas_c2_haz", haz_a0, 1);
    tick();
    chk("bas_c3_wbv", wb_valid0, 0);
    chk("bas_c3_haz", haz_a0, 0);
    chk("bas_c3_infl", infl0, 0);

    // Back-to-back captures sel=0,1,3 -> 3,5,29
    rd_addr_a = 5'd0;
    sel = 3'd0; sel_valid = 1'b1;
    tick(); chk("b2b_infl1", infl0, 1); chk("b2b_wbv1", wb_valid0, 0);
    sel = 3'd1;
    tick(); chk("b2b_infl2", infl0, 2); chk("b2b_wba2", wb_addr0, 3); chk("b2b_wbv2", wb_valid0, 1);
    sel = 3'd3;
    tick(); chk("b2b_infl3", infl0, 2); chk("b2b_wba3", wb_addr0, 5); chk("b2b_wbv3", wb_valid0, 1);
    sel_valid = 1'b0;
    tick(); chk("b2b_infl4", infl0, 1); chk("b2b_wba4", wb_addr0, 29); chk("b2b_wbv4", wb_valid0, 1);
    tick(); chk("b2b_infl5", infl0, 0); chk("b2b_wbv5", wb_valid0, 0);

    // Stall freezes the entry; flush (even with stall) drops everything
    rd_addr_a = 5'd31;
    sel = 3'd4; sel_valid = 1'b1;
    tick();
    chk("stl_cap_haz", haz_a0, 1);
    stall = 1'b1; sel = 3'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stl_infl", infl0, 1);
      chk("stl_haz", haz_a0, 1);
      chk("stl_wbv", wb_valid0, 0);
    end
    flush = 1'b1; sel = 3'd4;
    tick();
    chk("fl_infl", infl0, 0);
    chk("fl_haz", haz_a0, 0);
    chk("fl_wbv", wb_valid0, 0);
    flush = 1'b0; stall = 1'b0; sel_valid = 1'b0;
    tick(); chk("fl_wbv_a", wb_valid0, 0);
    tick(); chk("fl_wbv_b", wb_valid0, 0);

    // R0 suppression: captured address 0 never becomes valid
    src5 = {5'd31, 5'd29, 5'd8, 5'd5, 5'd0};
    rd_addr_b = 5'd0;
    sel = 3'd0; sel_valid = 1'b1;
    tick(); chk("r0_infl1", infl0, 0); chk("r0_hazb", haz_b0, 0);
    sel_valid = 1'b0;
    tick(); chk("r0_infl2", infl0, 0); chk("r0_wbv", wb_valid0, 0);

    // Bad select while stalled does not set sel_err
    stall = 1'b1; sel = 3'd7; sel_valid = 1'b1;
    tick(); chk("serr_stalled", serr0, 0);
    stall = 1'b0;

    // Bad select sel=6 falls back to source 4 (31) and sets sticky sel_err
    rd_addr_b = 5'd31;
    sel = 3'd6; sel_valid = 1'b1;
    tick();
    chk("bad_serr1", serr0, 1);
    chk("bad_hazb", haz_b0, 1);
    sel_valid = 1'b0;
    tick();
    chk("bad_wbv", wb_valid0, 1);
    chk("bad_wba", wb_addr0, 31);
    tick(); tick();
    chk("bad_serr_sticky", serr0, 1);
    chk("bad_hazb_gone", haz_b0, 0);
    reset = 1'b1; #1;
    chk("bad_serr_rst", serr0, 0);
    tick();
    reset = 1'b0;

    // Parameter sweep: eight sources, sel=7 legal, latency equals DEPTH
    sel = 3'd7; sel_valid = 1'b1;
    tick();
    chk("d1_wbv", wb_valid1, 1);
    chk("d1_wba", wb_addr1, 17);
    chk("d4_wbv1", wb_valid4, 0);
    chk("d4_infl1", infl4, 1);
    sel_valid = 1'b0;
    tick();
    chk("d1_wbv2", wb_valid1, 0);
    chk("d4_wbv2", wb_valid4, 0);
    tick();
    chk("d4_wbv3", wb_valid4, 0);
    tick();
    chk("d4_wbv4", wb_valid4, 1);
    chk("d4_wba4", wb_addr4, 17);
    chk("d4_infl4", infl4, 1);
    chk("d1_serr", serr1, 0);
    chk("d4_serr", serr4, 0);
    tick();
    chk("d4_wbv5", wb_valid4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
